pll_hdmi_drp_cfg: RTL
=====================

// Module: pll_hdmi_drp_cfg
// PURPOSE
//  DRP initiator that drives the reconfig_to_pll / reconfig_from_pll bus of the HDMI MMCM wrapper.
//  It accepts masked register-write commands and runs a read-modify-write per command, holding the MMCM in reset for the batch.
//  After the last command of a batch it releases the MMCM reset and waits for lock.
//  It sits between the video-mode/scaler config logic and pll_hdmi, in the management clock domain.
// PARAMETERS
//  DRDY_TIMEOUT  255    max clk cycles to wait for drdy per DRP access; on expiry error=1, batch aborted
//  LOCK_TIMEOUT  65535  max clk cycles to wait for locked after MMCM reset release; on expiry error=1
// PORTS
//  clk                clock is the single clock; also forwarded as DRP dclk
//  reset              input   1   asynchronous, active-high
//  cmd_valid          input   1   command present
//  cmd_ready          output  1   command accepted when cmd_valid & cmd_ready
//  cmd_addr           input   7   DRP register address
//  cmd_data           input   16  new bit values
//  cmd_mask           input   16  1 = keep current register bit, 0 = take cmd_data bit
//  cmd_last           input   1   final command of batch: release MMCM reset afterwards
//  busy               output  1   high from accept of first batch command until done/error
//  done               output  1   one-cycle pulse when locked is seen after a batch
//  error              output  1   sticky; set on either timeout; cleared by accept of the next command
//  reconfig_to_pll    output  64  [15:0]=din [22:16]=daddr [23]=den [24]=dwe [25]=rst_mmcm [26]=dclk; [63:27]=0
//  reconfig_from_pll  input   64  [15:0]=dout [16]=drdy [17]=locked; other bits ignored
// BEHAVIOUR
//  Reset values: cmd_ready=0, busy=0, done=0, error=0, den=0, dwe=0, rst_mmcm=0, din=0, daddr=0.
//  cmd_ready rises 1 cycle after reset deasserts.
//  dclk = clk (combinational forward). drdy and locked are sampled on the clk rising edge.
//  States:
//   IDLE:      cmd_ready=1. On accept: latch addr/data/mask/last, cmd_ready->0, busy->1, rst_mmcm->1.
//              If rst_mmcm was already 1 (mid-batch): -> RD. Otherwise -> RST (1 cycle), then RD.
//   RD:        den=1, dwe=0, daddr=addr for exactly 1 cycle -> WAIT_RD.
//   WAIT_RD:   on drdy, capture dout -> WR.
//   WR:        den=1, dwe=1, din=(dout & mask) | (cmd_data & ~mask) for exactly 1 cycle -> WAIT_WR.
//   WAIT_WR:   on drdy: if last -> REL; else -> IDLE with rst_mmcm held 1.
//   REL:       rst_mmcm->0, clear lock counter -> WAIT_LOCK.
//   WAIT_LOCK: on locked=1: done pulse 1 cycle, busy->0 -> IDLE.
//  den and dwe are never high on consecutive cycles. Only one DRP access is outstanding at a time.
//  Timeouts:
//   WAIT_RD/WAIT_WR counter exceeds DRDY_TIMEOUT: error=1, rst_mmcm->0, busy->0, -> IDLE (no done).
//   WAIT_LOCK counter exceeds LOCK_TIMEOUT: error=1, busy->0, -> IDLE.
//   The counter is reset on every state entry and saturates.
//  drdy is ignored outside the WAIT states. A drdy in the same cycle as timeout expiry counts as success.
//  A locked=1 already present on REL entry is not accepted: WAIT_LOCK requires locked sampled at least 1 cycle after rst_mmcm falls.
//  A batch with cmd_last=1 on its first command is a single-write batch.
//  An async reset mid-batch forces all outputs to reset values, including rst_mmcm=0.
//  The MMCM then restarts with partially written registers; the host must re-issue the full batch.
// CONFIGURATION
//  PLL_DRP_VERIFY_EN defined:
//   After WAIT_WR completes, adds states VRD/WAIT_VRD that read the same address back.
//   If readback != written value: error=1, rst_mmcm->0, batch aborted (no done).
//   Readback uses the same DRDY_TIMEOUT.
//  PLL_DRP_VERIFY_EN undefined: no readback. The WAIT_WR -> IDLE/REL transition is as above.
// TESTING
//  1. Reset, single cmd addr=0x08 data=0x1234 mask=0xF000 last=1; DRP model reg=0xA000 -> write din=0xA234, rst_mmcm high through write, done pulse after locked.
//  2. 3-command batch (last only on 3rd) -> rst_mmcm stays 1 across all, exactly 3 reads + 3 writes, one done.
//  3. DRP model never returns drdy on the read -> error=1 after DRDY_TIMEOUT+1 cycles, rst_mmcm=0, busy=0, no done; next accept clears error.
//  4. locked held 0 after release -> error=1 at LOCK_TIMEOUT; locked already 1 at REL entry -> done only after re-sample.
//  5. Async reset asserted during WAIT_WR -> all outputs reset values that cycle; cmd_ready=1 one cycle after release.
//  6. With PLL_DRP_VERIFY_EN, model corrupts bit 0 on write -> readback mismatch, error=1, no done; without the macro -> done.

Source files
------------

// File: rtl/pll_hdmi_drp_cfg.sv
// pll_hdmi_drp_cfg: DRP read-modify-write initiator for the HDMI MMCM; holds MMCM reset per batch, waits for lock.
// Optional readback verification enabled by defining PLL_DRP_VERIFY_EN.
`default_nettype none

module pll_hdmi_drp_cfg #(
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  input  logic        cmd_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] reconfig_to_pll,
  input  logic [63:0] reconfig_from_pll
);

  localparam int MAX_T = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_T + 2);
  localparam logic [CNT_W-1:0] DRDY_LIM = CNT_W'(DRDY_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RST       = 4'd1;
  localparam logic [3:0] S_RD        = 4'd2;
  localparam logic [3:0] S_WAIT_RD   = 4'd3;
  localparam logic [3:0] S_WR        = 4'd4;
  localparam logic [3:0] S_WAIT_WR   = 4'd5;
  localparam logic [3:0] S_REL       = 4'd6;
  localparam logic [3:0] S_WAIT_LOCK = 4'd7;
`ifdef PLL_DRP_VERIFY_EN
  localparam logic [3:0] S_VRD       = 4'd8;
  localparam logic [3:0] S_WAIT_VRD  = 4'd9;
`endif

  logic [3:0]       state, state_nxt;
  logic             started;
  logic [6:0]       addr;
  logic [15:0]      data, mask, wdata;
  logic             last;
  logic             rst_mmcm;
  logic             den, dwe;
  logic [CNT_W-1:0] cnt;

  logic [15:0] dout;
  logic        drdy, locked;
  logic        unused_from_pll;

  assign dout   = reconfig_from_pll[15:0];
  assign drdy   = reconfig_from_pll[16];
  assign locked = reconfig_from_pll[17];
  assign unused_from_pll = ^reconfig_from_pll[63:18];

  logic accept, wait_drdy, drdy_to, lock_ok, lock_to, vfy_bad;

  assign accept  = (state == S_IDLE) && started && cmd_valid;
  assign drdy_to = !drdy && (cnt >= DRDY_LIM);
  // The first WAIT_LOCK cycle is never trusted: locked must be sampled after rst_mmcm has been low a full cycle.
  assign lock_ok = locked && (cnt != '0);
  assign lock_to = !lock_ok && (cnt >= LOCK_LIM);

`ifdef PLL_DRP_VERIFY_EN
  assign wait_drdy = (state == S_WAIT_RD) || (state == S_WAIT_WR) || (state == S_WAIT_VRD);
  assign vfy_bad   = (state == S_WAIT_VRD) && drdy && (dout != wdata);
`else
  assign wait_drdy = (state == S_WAIT_RD) || (state == S_WAIT_WR);
  assign vfy_bad   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = rst_mmcm ? S_RD : S_RST;
      S_RST:       state_nxt = S_RD;
      S_RD:        state_nxt = S_WAIT_RD;
      S_WAIT_RD: begin
        if (drdy)         state_nxt = S_WR;
        else if (drdy_to) state_nxt = S_IDLE;
      end
      S_WR:        state_nxt = S_WAIT_WR;
      S_WAIT_WR: begin
`ifdef PLL_DRP_VERIFY_EN
        if (drdy)         state_nxt = S_VRD;
`else
        if (drdy)         state_nxt = last ? S_REL : S_IDLE;
`endif
        else if (drdy_to) state_nxt = S_IDLE;
      end
`ifdef PLL_DRP_VERIFY_EN
      S_VRD:       state_nxt = S_WAIT_VRD;
      S_WAIT_VRD: begin
        if (drdy)         state_nxt = (vfy_bad || !last) ? S_IDLE : S_REL;
        else if (drdy_to) state_nxt = S_IDLE;
      end
`endif
      S_REL:       state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_ok || lock_to) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = started && (state == S_IDLE);
    den       = 1'b0;
    dwe       = 1'b0;
    case (state)
      S_RD:    den = 1'b1;
      S_WR: begin
        den = 1'b1;
        dwe = 1'b1;
      end
`ifdef PLL_DRP_VERIFY_EN
      S_VRD:   den = 1'b1;
`endif
      default: ;
    endcase
  end

  // Command latch, MMCM reset control, status and timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started  <= 1'b0;
      addr     <= '0;
      data     <= '0;
      mask     <= '0;
      last     <= 1'b0;
      wdata    <= '0;
      busy     <= 1'b0;
      rst_mmcm <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      started <= 1'b1;
      done    <= 1'b0;

      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (accept) begin
        addr     <= cmd_addr;
        data     <= cmd_data;
        mask     <= cmd_mask;
        last     <= cmd_last;
        busy     <= 1'b1;
        rst_mmcm <= 1'b1;
        error    <= 1'b0;
      end

      if ((state == S_WAIT_RD) && drdy)
        wdata <= (dout & mask) | (data & ~mask);

      if ((wait_drdy && drdy_to) || vfy_bad) begin
        error    <= 1'b1;
        rst_mmcm <= 1'b0;
        busy     <= 1'b0;
      end

      if (state == S_REL) rst_mmcm <= 1'b0;

      if (state == S_WAIT_LOCK) begin
        if (lock_ok) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else if (lock_to) begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

  assign reconfig_to_pll = {37'd0, clk, rst_mmcm, dwe, den, addr, wdata};

endmodule

`default_nettype wire
